// File: rtl/seq_dispense_timer.sv
// Multi-channel dispense timer: runs motors for per-channel tick counts, sequentially or in parallel.
// Optional feature macro: SEQ_DISPENSE_PAUSE_EN adds a pause input that freezes a run in progress.
//
// state | meaning
// IDLE  | waiting for start; flags hold the result of the last run
// LOAD  | snapshot ciclos into counters, clear prescaler, select channel 0
// RUN   | prescaler ticking, counters decrementing, motors driven
// DONE  | one-cycle done pulse, then back to IDLE
module seq_dispense_timer #(
    parameter int N_CH     = 3,
    parameter int CNT_W    = 5,
    parameter int TICK_DIV = 4,
    parameter int MODE     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
`ifdef SEQ_DISPENSE_PAUSE_EN
    input  logic                    pause,
`endif
    input  logic [N_CH*CNT_W-1:0]   ciclos,
    output logic [N_CH-1:0]         motor,
    output logic [N_CH-1:0]         flags,
    output logic                    busy,
    output logic                    done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    presc, presc_n;
    logic [SW-1:0]    sel, sel_n;
    logic [CNT_W-1:0] cnt   [N_CH];
    logic [CNT_W-1:0] cnt_n [N_CH];
    logic [N_CH-1:0]  flags_n, motor_n;
    logic             pause_i, tick, hold, any_run;

`ifdef SEQ_DISPENSE_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    assign tick = (presc == PW'(TICK_DIV - 1));
    assign busy = (state == LOAD) || (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_n = state;
        presc_n = presc;
        sel_n   = sel;
        flags_n = flags;
        cnt_n   = cnt;
        motor_n = '0;
        hold    = 1'b0;
        any_run = 1'b0;
        if (abort) begin
            state_n = IDLE;
            presc_n = '0;
            sel_n   = '0;
            flags_n = '0;
            for (int i = 0; i < N_CH; i++) cnt_n[i] = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = LOAD;
                        flags_n = '0;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < N_CH; i++) cnt_n[i] = ciclos[i*CNT_W +: CNT_W];
                    presc_n = '0;
                    sel_n   = '0;
                    state_n = RUN;
                end
                RUN: begin
                    if (!pause_i) begin
                        if (MODE == 0) begin
                            // an exhausted selected channel costs one cycle to flag and move on
                            if (cnt[sel] == '0) begin
                                flags_n[sel] = 1'b1;
                                presc_n      = '0;
                                if (sel != SW'(N_CH - 1)) sel_n = sel + SW'(1);
                            end else begin
                                presc_n = tick ? '0 : presc + PW'(1);
                                if (tick) begin
                                    cnt_n[sel] = cnt[sel] - CNT_W'(1);
                                    if (cnt[sel] == CNT_W'(1)) flags_n[sel] = 1'b1;
                                end
                            end
                        end else begin
                            for (int i = 0; i < N_CH; i++) begin
                                if (cnt[i] == '0) begin
                                    flags_n[i] = 1'b1;
                                end else begin
                                    any_run = 1'b1;
                                    if (tick) begin
                                        cnt_n[i] = cnt[i] - CNT_W'(1);
                                        if (cnt[i] == CNT_W'(1)) flags_n[i] = 1'b1;
                                    end
                                end
                            end
                            if (any_run) presc_n = tick ? '0 : presc + PW'(1);
                        end
                        if (&flags_n) state_n = DONE;
                    end
                end
                DONE: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
        // motors follow the next-cycle channel selection so they rise on the LOAD/advance edge
        hold = pause_i && (state == RUN) && (state_n == RUN);
        for (int i = 0; i < N_CH; i++) begin
            motor_n[i] = (state_n == RUN) && (cnt_n[i] != '0) &&
                         ((MODE != 0) || (sel_n == SW'(i))) && !hold;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            presc <= '0;
            sel   <= '0;
            flags <= '0;
            motor <= '0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            state <= state_n;
            presc <= presc_n;
            sel   <= sel_n;
            flags <= flags_n;
            motor <= motor_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_seq_dispense_timer.sv
// Bench for seq_dispense_timer: sequential and parallel instances driven by the same stimulus,
// checked every cycle against a schedule model, plus hand-computed literal expectations.
module tb_seq_dispense_timer;
    localparam int N_CH  = 3;
    localparam int CNT_W = 5;
    localparam int TD    = 4;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, pause = 1'b0;
    logic [N_CH*CNT_W-1:0] ciclos = '0;
    logic [N_CH-1:0] m0, f0, m1, f1;
    logic b0, d0, b1, d1;

    always #5 clk = ~clk;

    seq_dispense_timer #(.N_CH(N_CH), .CNT_W(CNT_W), .TICK_DIV(TD), .MODE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef SEQ_DISPENSE_PAUSE_EN
        .pause(pause),
`endif
        .ciclos(ciclos), .motor(m0), .flags(f0), .busy(b0), .done(d0));

    seq_dispense_timer #(.N_CH(N_CH), .CNT_W(CNT_W), .TICK_DIV(TD), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef SEQ_DISPENSE_PAUSE_EN
        .pause(pause),
`endif
        .ciclos(ciclos), .motor(m1), .flags(f1), .busy(b1), .done(d1));

    int tests = 0, fails = 0, cyc = 0;

    // model: per instance, run phase and virtual run time r (edges since start, frozen while paused)
    int ph [2] = '{0, 0};
    int rt [2] = '{0, 0};
    logic [N_CH*CNT_W-1:0] snap [2] = '{'0, '0};
    logic [N_CH-1:0] ifl [2] = '{'0, '0};
    logic [N_CH-1:0] em [2] = '{'0, '0};
    logic [N_CH-1:0] ef [2] = '{'0, '0};
    logic eb [2] = '{1'b0, 1'b0};
    logic ed [2] = '{1'b0, 1'b0};

    int hi [2][N_CH];
    int h0 [2][N_CH];
    int rise [2][N_CH];
    int dcnt [2] = '{0, 0};
    int dc0 [2] = '{0, 0};
    logic [N_CH-1:0] prevm [2] = '{'0, '0};

    // Expected motors/flags at run time rr, and the run time at which done is reached.
    function automatic void sched(input int mode, input logic [N_CH*CNT_W-1:0] cc, input int rr,
                                  output logic [N_CH-1:0] m, output logic [N_CH-1:0] f, output int d);
        int t, c, fe;
        m = '0; f = '0; d = 0; t = 1;
        for (int i = 0; i < N_CH; i++) begin
            c = int'(cc[i*CNT_W +: CNT_W]);
            if (mode == 0) begin
                if (c > 0 && rr >= t && rr < t + c*TD) m[i] = 1'b1;
                fe = t + c*TD + ((c == 0) ? 1 : 0);
                t  = t + c*TD + 1;
            end else begin
                if (c > 0 && rr >= 1 && rr < 1 + c*TD) m[i] = 1'b1;
                fe = (c == 0) ? 2 : 1 + c*TD;
            end
            if (rr >= fe) f[i] = 1'b1;
            if (fe > d) d = fe;
        end
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; ifl[k] = '0; em[k] = '0; ef[k] = '0; eb[k] = 1'b0; ed[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [N_CH-1:0] m, f;
        int d;
        bit hold;
        for (int k = 0; k < 2; k++) begin
            hold = 1'b0;
            if (!reset || abort) begin
                ph[k] = 0; ifl[k] = '0;
            end else if (ph[k] == 0) begin
                if (start) begin ph[k] = 1; rt[k] = 0; snap[k] = ciclos; end
            end else begin
                sched(k, snap[k], rt[k], m, f, d);
                if (rt[k] == d) begin ph[k] = 0; ifl[k] = '1; end
                else if (rt[k] == 0) rt[k] = 1;
                else if (pause) hold = 1'b1;
                else rt[k] = rt[k] + 1;
            end
            if (ph[k] != 0) begin
                sched(k, snap[k], rt[k], m, f, d);
                em[k] = hold ? '0 : m; ef[k] = f; eb[k] = (rt[k] < d); ed[k] = (rt[k] == d);
            end else begin
                em[k] = '0; ef[k] = ifl[k]; eb[k] = 1'b0; ed[k] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    task automatic cmp_dut(input int k, input logic [N_CH-1:0] m, input logic [N_CH-1:0] f,
                           input logic b, input logic d);
        string p;
        p = (k == 0) ? "seq" : "par";
        chk({p, "_motor"}, int'(m), int'(em[k]));
        chk({p, "_flags"}, int'(f), int'(ef[k]));
        chk({p, "_busy"},  int'(b), int'(eb[k]));
        chk({p, "_done"},  int'(d), int'(ed[k]));
    endtask

    task automatic tick();
        logic [N_CH-1:0] m;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            m = (k == 0) ? m0 : m1;
            for (int c = 0; c < N_CH; c++) begin
                if (m[c]) hi[k][c]++;
                if (m[c] && !prevm[k][c]) rise[k][c] = cyc;
            end
            prevm[k] = m;
            if ((k == 0) ? d0 : d1) dcnt[k]++;
        end
        cmp_dut(0, m0, f0, b0, d0);
        cmp_dut(1, m1, f1, b1, d1);
    endtask

    task automatic snap_stats();
        for (int k = 0; k < 2; k++) begin
            dc0[k] = dcnt[k];
            for (int c = 0; c < N_CH; c++) h0[k][c] = hi[k][c];
        end
    endtask

    task automatic pulse_start(input logic [N_CH*CNT_W-1:0] cc);
        ciclos = cc;
        snap_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_hi(input string nm, input int k, input int e0, input int e1, input int e2);
        chk({nm, "_hi0"}, hi[k][0] - h0[k][0], e0);
        chk({nm, "_hi1"}, hi[k][1] - h0[k][1], e1);
        chk({nm, "_hi2"}, hi[k][2] - h0[k][2], e2);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N_CH; c++) begin hi[k][c] = 0; h0[k][c] = 0; rise[k][c] = 0; end

        // reset
        repeat (3) tick();
        chk("rst_motor", int'(m0), 0);
        chk("rst_flags", int'(f0), 0);
        chk("rst_busy", int'(b0), 0);
        chk("rst_done", int'(d0), 0);
        reset = 1'b1;
        repeat (2) tick();

        // sequential run R=2 G=0 B=3; ciclos scrambled after LOAD must not matter
        pulse_start({5'd3, 5'd0, 5'd2});
        tick();
        ciclos = '1;
        n = 0;
        while (!m0[2] && n < 40) begin tick(); n++; end
        chk("A_m2_rise_seen", int'(m0[2]), 1);
        chk("A_flags_at_m2", int'(f0), 3'b011);
        n = 0;
        while (!d0 && n < 60) begin tick(); n++; end
        chk("A_done_seen", int'(d0), 1);
        repeat (3) tick();
        chk_hi("A_seq", 0, 8, 0, 12);
        chk_hi("A_par", 1, 8, 0, 12);
        chk("A_seq_dones", dcnt[0] - dc0[0], 1);
        chk("A_par_dones", dcnt[1] - dc0[1], 1);
        chk("A_seq_flags", int'(f0), 3'b111);

        // parallel counts 1,3,2
        pulse_start({5'd2, 5'd3, 5'd1});
        n = 0;
        while ((dcnt[0] - dc0[0]) < 1 && n < 80) begin tick(); n++; end
        repeat (3) tick();
        chk_hi("B_par", 1, 4, 12, 8);
        chk("B_par_rise_together1", rise[1][1] - rise[1][0], 0);
        chk("B_par_rise_together2", rise[1][2] - rise[1][0], 0);
        chk("B_par_dones", dcnt[1] - dc0[1], 1);
        chk_hi("B_seq", 0, 4, 12, 8);

        // abort five cycles into motor[1]
        pulse_start({5'd3, 5'd2, 5'd1});
        n = 0;
        while (!m0[1] && n < 30) begin tick(); n++; end
        chk("C_m1_rise_seen", int'(m0[1]), 1);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("C_motor", int'(m0), 0);
        chk("C_flags", int'(f0), 0);
        chk("C_busy", int'(b0), 0);
        chk("C_par_motor", int'(m1), 0);
        repeat (6) tick();
        chk("C_seq_no_done", dcnt[0] - dc0[0], 0);
        chk("C_par_no_done", dcnt[1] - dc0[1], 0);

        // all-zero counts
        pulse_start('0);
        n = 1;
        while (!d0 && n < 10) begin tick(); n++; end
        chk("D_done_seen", int'(d0), 1);
        chk("D_done_within_5", int'(n <= 5), 1);
        repeat (3) tick();
        chk_hi("D_seq", 0, 0, 0, 0);
        chk("D_flags", int'(f0), 3'b111);

        // start held: busy ignores it, idle after done re-triggers
        ciclos = {5'd1, 5'd1, 5'd1};
        snap_stats();
        start = 1'b1;
        n = 0;
        while ((dcnt[0] - dc0[0]) < 2 && n < 120) begin tick(); n++; end
        start = 1'b0;
        repeat (25) tick();
        chk("E_seq_dones", dcnt[0] - dc0[0], 2);

        // reset pulse mid-run
        pulse_start({5'd2, 5'd2, 5'd2});
        repeat (6) tick();
        #2 reset = 1'b0;
        #1;
        chk("F_async_motor", int'(m0), 0);
        chk("F_async_busy", int'(b0), 0);
        chk("F_async_flags", int'(f0), 0);
        chk("F_async_par_motor", int'(m1), 0);
        model_clear();
        tick();
        reset = 1'b1;
        repeat (10) tick();
        chk("F_stays_idle", int'(b0 | b1), 0);

`ifdef SEQ_DISPENSE_PAUSE_EN
        // pause 10 cycles during motor[0]
        pulse_start({5'd3, 5'd0, 5'd2});
        n = 0;
        while (!m0[0] && n < 10) begin tick(); n++; end
        repeat (2) tick();
        pause = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (!m0[0]) n++; end
        pause = 1'b0;
        chk("G_low_while_paused", n, 10);
        n = 0;
        while ((dcnt[0] - dc0[0]) < 1 && n < 80) begin tick(); n++; end
        repeat (3) tick();
        chk_hi("G_seq", 0, 8, 0, 12);
        chk_hi("G_par", 1, 8, 0, 12);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_dispense_timer.md
SEQ_DISPENSE_TIMER -- requirements
Module: seq_dispense_timer

Interface
REQ-001 SHALL have parameter N_CH, default 3: number of dispense channels (motors), 1..8.
REQ-002 SHALL have parameter CNT_W, default 5: width of each channel's cycle count.
REQ-003 SHALL have parameter TICK_DIV, default 4: clk cycles per dispense tick, >=1.
REQ-004 SHALL have parameter MODE, default 0: 0 = sequential channels, 1 = parallel channels.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: level-sampled run request.
REQ-008 SHALL have port abort, input, 1: cancels the run in progress.
REQ-009 SHALL have port ciclos, input, N_CH*CNT_W: per-channel tick counts; channel i is at bits [i*CNT_W +: CNT_W].
REQ-010 SHALL have port motor, output, N_CH: registered motor enables, one per channel.
REQ-011 SHALL have port flags, output, N_CH: registered per-channel completion flags.
REQ-012 SHALL have port busy, output, 1: high in LOAD and RUN.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when every channel completes.

Function
REQ-014 SHALL implement states IDLE, LOAD, RUN and DONE.
REQ-015 IDLE: start=1 and abort=0 -> LOAD; flags cleared to 0 on the same edge.
REQ-016 LOAD (1 cycle): snapshot ciclos into internal counters, clear the prescaler, select channel 0, go to RUN; ciclos changes after LOAD SHALL be ignored.
REQ-017 The prescaler SHALL count 0..TICK_DIV-1 in RUN only; tick = prescaler at TICK_DIV-1; it SHALL wrap to 0.
REQ-018 A zero count SHALL set that channel's flag without asserting its motor; sequential mode SHALL skip that channel in 1 cycle.
REQ-019 MODE=0: only the selected channel's motor is high; on each tick its counter decrements.
REQ-020 MODE=0: on the tick that reaches 0, the motor SHALL drop and the flag rise on the same edge; the next channel is selected on the following cycle and the prescaler restarts from 0.
REQ-021 MODE=1: all non-zero channels run at once, each decrementing on the shared tick and stopping/flagging independently.
REQ-022 Motor i SHALL rise the first cycle in RUN with channel i active and count non-zero; it stays high for exactly count*TICK_DIV clk cycles.
REQ-023 When all flags=1, the FSM SHALL enter DONE, pulse done for 1 cycle, then return to IDLE; flags hold until the next LOAD.
REQ-024 start while busy SHALL be ignored; start held high in IDLE after DONE SHALL re-trigger a run.
REQ-025 abort=1 in any state SHALL return to IDLE on the next edge: motors 0, counters 0, flags 0, no done pulse; abort has priority over start and tick.
REQ-026 Counter decrement SHALL never underflow below 0.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, motor=0, flags=0, busy=0, done=0, prescaler and counters 0.
REQ-028 Reset release mid-run SHALL leave the block idle; a new start is required.

Configuration
REQ-029 With macro SEQ_DISPENSE_PAUSE_EN defined, port pause (input, 1) SHALL exist: pause=1 in RUN freezes prescaler and counters and forces motor=0; motors resume from the same count when pause=0; abort overrides pause.
REQ-030 Without SEQ_DISPENSE_PAUSE_EN, port pause and its logic SHALL be absent, and behaviour is as in REQ-014..026.

Verification
REQ-031 Defaults, ciclos R=2,G=0,B=3, start pulse -> motor[0] high 8 clk, flags=001; G skipped, flags=011; motor[2] high 12 clk; done pulse; flags=111.
REQ-032 MODE=1, counts 1,3,2, TICK_DIV=4 -> all motors rise together; they fall after 4, 12 and 8 clk; a single done pulse follows.
REQ-033 Abort 5 clk into motor[1] run -> next edge: motor=0, flags=000, busy=0, no done pulse.
REQ-034 All counts 0 + start -> no motor activity, flags=111, done within 5 clk of start.
REQ-035 reset low mid-run for 1 cycle -> outputs 0 asynchronously; the block stays IDLE until start.
REQ-036 SEQ_DISPENSE_PAUSE_EN, pause 10 clk during motor[0] -> motor low for 10 clk; total high time still count*TICK_DIV.
